// File: rtl/deal_pacer.sv
// Paces card deals from the slow divided clock: synchronises it into the system
// clock domain, turns its rising edges into ticks, and spaces req/ack deal requests.
module deal_pacer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TICKS_PER_DEAL = 1
) (
    input  logic       iclk,
    input  logic       ireset_n,
    input  logic       islowclk,
    input  logic       istart,
    input  logic [2:0] incards,
    input  logic       iabort,
    input  logic       ideal_ack,
    output logic       odeal,
    output logic       otick,
    output logic       obusy,
    output logic       odone,
    output logic [2:0] oremaining
);

    typedef enum logic [1:0] {IDLE, DEAL, WAIT, DONE} state_t;

    localparam logic [3:0] TPD = 4'(TICKS_PER_DEAL);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [2:0]             remaining;
    logic [3:0]             tcnt;

    // The tick path keeps running through abort; only reset clears it.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            otick <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], islowclk};
            prev  <= sync[SYNC_STAGES-1];
            otick <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state     <= IDLE;
            remaining <= '0;
            tcnt      <= '0;
        end else if (iabort) begin
            state     <= IDLE;
            remaining <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (istart) begin
                        remaining <= incards;
                        state     <= (incards != 3'd0) ? DEAL : DONE;
                    end
                end
                DEAL: begin
                    if (ideal_ack) begin
                        remaining <= remaining - 3'd1;
                        tcnt      <= '0;
                        state     <= (remaining == 3'd1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (otick) begin
                        if (tcnt + 4'd1 >= TPD) begin
                            tcnt  <= TPD;
                            state <= DEAL;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign odeal      = (state == DEAL);
    assign obusy      = (state != IDLE);
    assign odone      = (state == DONE);
    assign oremaining = remaining;

endmodule

// File: tb/tb_deal_pacer.sv
// Scoreboard bench for deal_pacer: directed sequences push expected tick/deal/done
// events with hand-computed cycle numbers; a negedge monitor pops and compares them.
module tb_deal_pacer;

    logic       iclk      = 1'b0;
    logic       ireset_n  = 1'b0;
    logic       islowclk  = 1'b0;
    logic       istart    = 1'b0;
    logic [2:0] incards   = 3'd0;
    logic       iabort    = 1'b0;
    logic       ideal_ack = 1'b0;
    logic       odeal, otick, obusy, odone;
    logic [2:0] oremaining;

    int  cyc      = 0;
    int  errors   = 0;
    int  checks   = 0;
    int  ack_mode = 0;
    bit  tick_en  = 1'b1;
    logic odeal_q = 1'b0;

    typedef enum int {EV_TICK, EV_DEAL, EV_DONE} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
        int  rem;
    } ev_s;

    ev_s sb[$];

    deal_pacer #(.SYNC_STAGES(2), .TICKS_PER_DEAL(2)) u_dut (
        .iclk       (iclk),
        .ireset_n   (ireset_n),
        .islowclk   (islowclk),
        .istart     (istart),
        .incards    (incards),
        .iabort     (iabort),
        .ideal_ack  (ideal_ack),
        .odeal      (odeal),
        .otick      (otick),
        .obusy      (obusy),
        .odone      (odone),
        .oremaining (oremaining)
    );

    always #5 iclk = ~iclk;

    // cyc == e after posedge number e; all cycle numbers below use this count.
    always @(posedge iclk) cyc <= cyc + 1;

    // Slow clock: high for cycles 8..15 of every 16, so ticks land at 16j+11.
    initial forever begin
        @(posedge iclk);
        #1;
        islowclk = cyc[3];
    end

    initial forever begin
        @(posedge iclk);
        #1;
        if (ack_mode == 1)      ideal_ack = odeal;
        else if (ack_mode == 2) ideal_ack = 1'b1;
    end

    function automatic void expect_ev(ev_t k, int c, int r);
        ev_s e;
        e.kind = k;
        e.cyc  = c;
        e.rem  = r;
        sb.push_back(e);
    endfunction

    task automatic see(ev_t k);
        ev_s e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got %s at cycle %0d, required no event", k.name(), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc || e.rem != int'(oremaining) || (k != EV_TICK && !obusy)) begin
                errors++;
                $display("FAIL event_%s: got %s cyc=%0d rem=%0d busy=%0b, required %s cyc=%0d rem=%0d",
                         e.kind.name(), k.name(), cyc, oremaining, obusy, e.kind.name(), e.cyc, e.rem);
            end
        end
    endtask

    always @(negedge iclk) begin
        if (tick_en && otick) see(EV_TICK);
        if (odeal && !odeal_q) see(EV_DEAL);
        if (odone) see(EV_DONE);
        odeal_q = odeal;
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic start(int c, int n);
        at(c);
        istart  = 1'b1;
        incards = 3'(n);
        at(c + 1);
        istart  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        expect_ev(EV_TICK, 11, 0);
        expect_ev(EV_TICK, 27, 0);
        expect_ev(EV_TICK, 43, 0);

        at(2);
        check("reset_odeal", int'(odeal), 0);
        check("reset_otick", int'(otick), 0);
        check("reset_obusy", int'(obusy), 0);
        check("reset_odone", int'(odone), 0);
        check("reset_oremaining", int'(oremaining), 0);
        at(3);
        ireset_n = 1'b1;
        at(50);
        tick_en = 1'b0;

        // Three cards, ack one cycle after each request; ticks sampled at 76/92, 108/124.
        at(55);
        ack_mode = 1;
        expect_ev(EV_DEAL, 61, 3);
        expect_ev(EV_DEAL, 92, 2);
        expect_ev(EV_DEAL, 124, 1);
        expect_ev(EV_DONE, 125, 0);
        start(60, 3);
        at(126);
        check("idle_after_done_obusy", int'(obusy), 0);
        check("idle_after_done_odone", int'(odone), 0);

        expect_ev(EV_DONE, 131, 0);
        start(130, 0);
        at(132);
        check("zero_cards_idle_obusy", int'(obusy), 0);

        // Abort while waiting between deals.
        expect_ev(EV_DEAL, 141, 5);
        start(140, 5);
        at(145);
        iabort = 1'b1;
        at(146);
        iabort = 1'b0;
        check("abort_odeal", int'(odeal), 0);
        check("abort_obusy", int'(obusy), 0);
        check("abort_oremaining", int'(oremaining), 0);
        check("abort_odone", int'(odone), 0);
        expect_ev(EV_DEAL, 151, 1);
        expect_ev(EV_DONE, 152, 0);
        start(150, 1);

        // Ack held high throughout.
        at(156);
        ack_mode = 2;
        expect_ev(EV_DEAL, 161, 2);
        expect_ev(EV_DEAL, 188, 1);
        expect_ev(EV_DONE, 189, 0);
        start(160, 2);
        at(162);
        check("held_ack_first_deal_width", int'(odeal), 0);
        at(189);
        check("held_ack_second_deal_width", int'(odeal), 0);

        // Ack sampled at 204 together with a tick; that tick must not count.
        at(195);
        ack_mode = 1;
        expect_ev(EV_DEAL, 203, 2);
        expect_ev(EV_DEAL, 236, 1);
        expect_ev(EV_DONE, 237, 0);
        start(202, 2);

        // istart during DEAL is ignored; the request stays held without ack.
        at(245);
        ack_mode  = 0;
        ideal_ack = 1'b0;
        expect_ev(EV_DEAL, 251, 3);
        start(250, 3);
        start(253, 6);
        at(255);
        check("start_in_deal_oremaining", int'(oremaining), 3);
        check("start_in_deal_odeal_held", int'(odeal), 1);
        check("start_in_deal_obusy", int'(obusy), 1);
        at(256);
        iabort = 1'b1;
        at(257);
        iabort = 1'b0;
        check("abort_in_deal_odeal", int'(odeal), 0);
        check("abort_in_deal_oremaining", int'(oremaining), 0);

        at(265);
        check("scoreboard_missing_events", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deal_pacer.md
# deal_pacer

Paces card dealing for the BlackJack game logic using the slow divided clock from the clock divider. It synchronizes the divided clock into the 50 MHz domain and converts its rising edges into one-cycle ticks. It then issues a counted series of deal requests, spaced by a programmable number of ticks, to the downstream card/deck logic over a req/ack handshake.

## Interface
- SYNC_STAGES, 2, synchronizer flops on islowclk (≥2)
- TICKS_PER_DEAL, 1, slow-clock rising edges between consecutive deals (1..15)
- iclk  in  1  50 MHz system clock; all logic on posedge
- ireset_n  in  1  asynchronous, active-low reset
- islowclk  in  1  divided clock from the clock divider; asynchronous to this block's logic, treated as data
- istart  in  1  one-cycle start request
- incards  in  3  number of cards to deal (0..7), sampled with istart
- iabort  in  1  return to idle immediately
- ideal_ack  in  1  downstream has consumed the current card
- odeal  out  1  deal request, held until acknowledged
- otick  out  1  one-cycle pulse per islowclk rising edge
- obusy  out  1  sequence in progress
- odone  out  1  one-cycle pulse when all cards have been dealt
- oremaining  out  3  cards still to be dealt

## Operation
- Reset (async, ireset_n=0): state IDLE; all synchronizer flops, the edge flop, the tick counter and the remaining counter are 0; odeal, otick, obusy and odone are 0; oremaining is 0.
- Tick path: islowclk → SYNC_STAGES flops → edge flop `prev`; registered `otick <= sync_last & ~prev`.
  - If islowclk is high at reset release, one tick is generated by design.
- States: IDLE, DEAL, WAIT, DONE. The outputs are decoded from registered state:
  - odeal = (DEAL)
  - obusy = (DEAL|WAIT|DONE)
  - odone = (DONE)
- IDLE:
  - istart with incards≠0: latch remaining=incards, go to DEAL. The first card is dealt with no wait.
  - istart with incards=0: go to DONE.
- DEAL:
  - ideal_ack: remaining decrements. If the new value is 0, go to DONE. Otherwise go to WAIT with the tick counter cleared.
  - No ack: stay in DEAL, odeal held.
- WAIT: count otick pulses. When the count reaches TICKS_PER_DEAL, go to DEAL.
- DONE: lasts one cycle, then IDLE.
- iabort (any state): go to IDLE next edge and clear remaining. No odone is generated. iabort has priority over istart, ideal_ack and tick.
- Ignored inputs:
  - istart outside IDLE.
  - ideal_ack outside DEAL.
  - otick outside WAIT. On WAIT entry the counter is cleared, so a tick coincident with the entering ack is not counted.
- oremaining = remaining register. The decrement happens on the ack edge and never wraps, because DEAL is never entered with remaining=0.
- The tick counter is 4 bits and saturates at TICKS_PER_DEAL.

## Timing
- islowclk rising, first sampled high at edge k → otick high for exactly the cycle after edge k+SYNC_STAGES (k+2 by default).
- istart sampled at edge k → odeal=1, obusy=1, oremaining=incards after edge k.
- ideal_ack sampled at edge m → odeal=0 after edge m.
  - If that was the last card: odone=1 after m, odone=0 and obusy=0 after m+1.
- In WAIT, the TICKS_PER_DEAL-th otick sampled at edge n → odeal=1 after edge n.
- ideal_ack may be held high continuously. Each DEAL visit consumes exactly one ack, in its first DEAL cycle.
- iabort sampled at edge a → all outputs except otick at reset values after edge a. Tick synchronizer state is unaffected.

## Test plan
- Reset with islowclk=0, then toggle islowclk every 8 cycles → otick pulses one cycle wide, 2 cycles after each sampled rise, 16 cycles apart; no pulse on falls.
- incards=3, TICKS_PER_DEAL=2, ack 1 cycle after each odeal → odeal immediately; next two deals each follow the 2nd subsequent otick; oremaining 3→2→1→0; odone single pulse; obusy low next cycle.
- istart with incards=0 → odone pulse one cycle after start; odeal never asserts.
- Abort mid-WAIT (incards=5, after first ack) → odeal/obusy/oremaining=0 next cycle, no odone; new istart works normally.
- Holding ideal_ack high throughout with incards=2 → exactly 2 deals, each odeal lasting 1 cycle.
- otick coincident with the ack entering WAIT → not counted; with TICKS_PER_DEAL=1, the next otick triggers DEAL.
- istart asserted while in DEAL → ignored; oremaining is unchanged.
